// File: rtl/text_pkg.sv
// Shared text-mode constants, types and helpers for the text buffer and the pixel encoder.
// The optional cursor blink (macro CURSOR_BLINK_EN) uses BLINK_DIV from here.
package text_pkg;

    localparam int unsigned ROWS       = 7;
    localparam int unsigned COLS       = 20;
    localparam int unsigned ROW_BITS   = 4;
    localparam int unsigned COL_BITS   = 6;
    localparam int unsigned CHAR_BITS  = 8;
    localparam int unsigned NUM_GLYPHS = 130;
    localparam int unsigned BLINK_DIV  = 25_000_000;

    localparam int unsigned CELLS     = ROWS * COLS;
    localparam int unsigned ADDR_BITS = $clog2(CELLS);

    typedef logic [ROW_BITS-1:0]  row_t;
    typedef logic [COL_BITS-1:0]  col_t;
    typedef logic [CHAR_BITS-1:0] char_t;
    typedef logic [ADDR_BITS-1:0] addr_t;

    localparam char_t BLANK_CHAR  = 8'h20;
    localparam char_t CURSOR_CHAR = 8'h5F;

    localparam char_t CC_BS = 8'h08;
    localparam char_t CC_LF = 8'h0A;
    localparam char_t CC_FF = 8'h0C;
    localparam char_t CC_CR = 8'h0D;

    typedef logic [1:0] state_t;
    localparam state_t StIdle   = 2'd0;
    localparam state_t StScroll = 2'd1;
    localparam state_t StClrRow = 2'd2;
    localparam state_t StClear  = 2'd3;

    localparam row_t  ROW_LAST    = row_t'(ROWS - 1);
    localparam col_t  COL_LAST    = col_t'(COLS - 1);
    localparam addr_t IDX_LAST    = addr_t'(CELLS - 1);
    localparam addr_t SCROLL_LAST = addr_t'((ROWS - 1) * COLS - 1);
    localparam addr_t ROW_STRIDE  = addr_t'(COLS);

    function automatic addr_t cell_addr(input row_t r, input col_t c);
        int unsigned a;
        a = 32'(r) * COLS + 32'(c);
        return addr_t'(a);
    endfunction

    function automatic logic is_printable(input char_t code);
        return (code >= BLANK_CHAR) && (32'(code) < NUM_GLYPHS);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Character storage: one synchronous write port and two asynchronous read ports
// (display lookup and scroll source), intended to map onto distributed RAM.
module text_ram
    import text_pkg::*;
#(
    parameter int unsigned Depth = CELLS
) (
    input  logic  clk_i,
    input  logic  we_i,
    input  addr_t waddr_i,
    input  char_t wdata_i,
    input  addr_t disp_addr_i,
    output char_t disp_data_o,
    input  addr_t src_addr_i,
    output char_t src_data_o
);

    char_t mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Addresses past the last cell never index the array.
    assign disp_data_o = (32'(disp_addr_i) < Depth) ? mem_q[disp_addr_i] : BLANK_CHAR;
    assign src_data_o  = (32'(src_addr_i) < Depth) ? mem_q[src_addr_i] : BLANK_CHAR;

endmodule

// File: rtl/text_buffer_ctrl.sv
// Text buffer controller: byte-stream glyph writes, cursor tracking, scroll and clear sequencing.
// Define CURSOR_BLINK_EN to overlay a blinking underscore at the cursor on the read port.
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    input  char_t in_data,
    output logic  in_ready,
    input  row_t  rin,
    input  col_t  cin,
    output char_t charout,
    output row_t  cur_row,
    output col_t  cur_col,
    output logic  busy
);

    state_t state_q, state_d;
    addr_t  idx_q, idx_d;
    row_t   row_q, row_d;
    col_t   col_q, col_d;

    logic  we, we_c;
    addr_t waddr;
    char_t wdata;
    addr_t disp_addr, src_addr;
    char_t disp_data, src_data;
    logic  in_range;
    logic  show_cursor;
    logic  fire;

    assign in_ready = (state_q == StIdle) && !reset;
    assign busy     = (state_q != StIdle);
    assign fire     = in_valid && in_ready;
    assign cur_row  = row_q;
    assign cur_col  = col_q;

    assign src_addr = idx_q + ROW_STRIDE;
    assign we       = we_c && !reset;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        we_c    = 1'b0;
        waddr   = idx_q;
        wdata   = BLANK_CHAR;
        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    if (is_printable(in_data)) begin
                        we_c  = 1'b1;
                        waddr = cell_addr(row_q, col_q);
                        wdata = in_data;
                        if (col_q < COL_LAST) begin
                            col_d = col_q + col_t'(1);
                        end else begin
                            col_d = '0;
                            if (row_q < ROW_LAST) begin
                                row_d = row_q + row_t'(1);
                            end else begin
                                state_d = StScroll;
                                idx_d   = '0;
                            end
                        end
                    end else if (in_data == CC_LF || in_data == CC_CR) begin
                        col_d = '0;
                        if (row_q < ROW_LAST) begin
                            row_d = row_q + row_t'(1);
                        end else begin
                            state_d = StScroll;
                            idx_d   = '0;
                        end
                    end else if (in_data == CC_BS) begin
                        if (col_q != '0) begin
                            col_d = col_q - col_t'(1);
                            we_c  = 1'b1;
                            waddr = cell_addr(row_q, col_q - col_t'(1));
                        end else if (row_q != '0) begin
                            row_d = row_q - row_t'(1);
                            col_d = COL_LAST;
                            we_c  = 1'b1;
                            waddr = cell_addr(row_q - row_t'(1), COL_LAST);
                        end
                    end else if (in_data == CC_FF) begin
                        state_d = StClear;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end
                end
            end
            StScroll: begin
                // Pull each cell up by one row; the index then runs on through the last row.
                we_c  = 1'b1;
                wdata = src_data;
                idx_d = idx_q + addr_t'(1);
                if (idx_q == SCROLL_LAST) begin
                    state_d = StClrRow;
                end
            end
            StClrRow, StClear: begin
                we_c = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + addr_t'(1);
                end
            end
            default: begin
                state_d = StClear;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign in_range  = (rin < row_t'(ROWS)) && (cin < col_t'(COLS));
    assign disp_addr = cell_addr(rin, cin);

    text_ram #(
        .Depth(CELLS)
    ) u_ram (
        .clk_i      (clk),
        .we_i       (we),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .disp_addr_i(disp_addr),
        .disp_data_o(disp_data),
        .src_addr_i (src_addr),
        .src_data_o (src_data)
    );

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BLINK_BITS = $clog2(BLINK_DIV);

    logic [BLINK_BITS-1:0] blink_cnt_q;
    logic                  blink_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_BITS'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
        end
    end

    assign show_cursor = blink_q && (state_q == StIdle) && (rin == row_q) && (cin == col_q);
`else
    assign show_cursor = 1'b0;
`endif

    always_comb begin
        charout = BLANK_CHAR;
        if (show_cursor) begin
            charout = CURSOR_CHAR;
        end else if (in_range) begin
            charout = disp_data;
        end
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Scoreboard bench for text_buffer_ctrl: stimulus queues expected cell/cursor values,
// a monitor pops and compares them whenever the block is idle and ready.
module tb_text_buffer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] rin = 4'd0;
    logic [5:0] cin = 6'd0;
    logic [7:0] charout;
    logic [3:0] cur_row;
    logic [5:0] cur_col;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] r;
        logic [5:0] c;
        logic [7:0] ch;
        bit         cur;
        logic [3:0] er;
        logic [5:0] ec;
    } item_t;

    item_t sb_q[$];

    always #5 clk = ~clk;

    text_buffer_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .rin     (rin),
        .cin     (cin),
        .charout (charout),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy    (busy)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_cell(input logic [3:0] r, input logic [5:0] c, input logic [7:0] ch);
        item_t it;
        it.r = r; it.c = c; it.ch = ch; it.cur = 1'b0; it.er = '0; it.ec = '0;
        sb_q.push_back(it);
    endtask

    task automatic push_cur(input logic [3:0] r, input logic [5:0] c, input logic [7:0] ch,
                            input logic [3:0] er, input logic [5:0] ec);
        item_t it;
        it.r = r; it.c = c; it.ch = ch; it.cur = 1'b1; it.er = er; it.ec = ec;
        sb_q.push_back(it);
    endtask

    task automatic push_row(input logic [3:0] r, input logic [7:0] ch);
        for (int i = 0; i < 20; i++) push_cell(r, 6'(i), ch);
    endtask

    // Monitor: compares one queued expectation per idle cycle.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0 && in_ready && !in_valid && !reset) begin
                it = sb_q.pop_front();
                rin = it.r;
                cin = it.c;
                #1;
                check($sformatf("cell(%0d,%0d)", it.r, it.c), int'(charout), int'(it.ch));
                if (it.cur) begin
                    check("cursor row", int'(cur_row), int'(it.er));
                    check("cursor col", int'(cur_col), int'(it.ec));
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            check("scoreboard drain timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send handshake timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset clear: 140 busy cycles, all blank, cursor home.
        count_busy(n);
        check("reset clear busy cycles", n, 140);
        check("in_ready after clear", int'(in_ready), 1);
        push_cur(4'd0, 6'd0, 8'h20, 4'd0, 6'd0);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 20; c++)
                if (r != 0 || c != 0) push_cell(4'(r), 6'(c), 8'h20);
        drain();

        send(8'h41);
        push_cur(4'd0, 6'd0, 8'h41, 4'd0, 6'd1);
        drain();

        // Backspace from (0,1) blanks (0,0); a second one at home is a no-op.
        send(8'h08);
        push_cur(4'd0, 6'd0, 8'h20, 4'd0, 6'd0);
        drain();
        send(8'h08);
        push_cur(4'd0, 6'd0, 8'h20, 4'd0, 6'd0);
        push_cell(4'd0, 6'd1, 8'h20);
        drain();

        for (int i = 0; i < 20; i++) send(8'h42);
        push_cur(4'd0, 6'd0, 8'h42, 4'd1, 6'd0);
        for (int i = 1; i < 20; i++) push_cell(4'd0, 6'(i), 8'h42);
        drain();

        // Backspace at column 0 wraps to the end of the previous row.
        send(8'h08);
        push_cur(4'd0, 6'd19, 8'h20, 4'd0, 6'd19);
        push_cell(4'd0, 6'd18, 8'h42);
        drain();
        send(8'h42);
        push_cur(4'd0, 6'd19, 8'h42, 4'd1, 6'd0);
        drain();

        for (int i = 0; i < 20; i++) send(8'(8'h61 + i));
        for (int i = 0; i < 20; i++) push_cell(4'd1, 6'(i), 8'(8'h61 + i));
        push_cur(4'd2, 6'd0, 8'h20, 4'd2, 6'd0);
        drain();

        send(8'h0A);
        send(8'h0D);
        send(8'h0A);
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'(8'h31 + i));
        push_cur(4'd6, 6'd0, 8'h31, 4'd6, 6'd5);
        push_cell(4'd6, 6'd4, 8'h35);
        drain();

        // Newline on the last row scrolls; the next byte waits out the scroll.
        send(8'h0A);
        in_data  = 8'h43;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("held byte wait cycles", n, 140);
        check("busy at accept", int'(busy), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) push_cell(4'd0, 6'(i), 8'(8'h61 + i));
        push_cell(4'd1, 6'd0, 8'h20);
        push_cell(4'd4, 6'd0, 8'h20);
        for (int i = 0; i < 5; i++) push_cell(4'd5, 6'(i), 8'(8'h31 + i));
        push_cell(4'd5, 6'd5, 8'h20);
        push_cur(4'd6, 6'd0, 8'h43, 4'd6, 6'd1);
        for (int i = 1; i < 20; i++) push_cell(4'd6, 6'(i), 8'h20);
        drain();

        // Codes at or above the glyph count are swallowed.
        send(8'h90);
        send(8'h01);
        push_cur(4'd6, 6'd1, 8'h20, 4'd6, 6'd1);
        push_cell(4'd6, 6'd0, 8'h43);
        push_cell(4'd7, 6'd0, 8'h20);
        push_cell(4'd2, 6'd20, 8'h20);
        push_cell(4'd15, 6'd63, 8'h20);
        drain();

        // Reset mid-scroll restarts a full clear.
        send(8'h0A);
        repeat (30) @(negedge clk);
        check("busy mid scroll", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_busy(n);
        check("clear after mid-scroll reset", n, 140);
        push_cur(4'd5, 6'd0, 8'h20, 4'd0, 6'd0);
        push_cell(4'd6, 6'd0, 8'h20);
        push_cell(4'd0, 6'd0, 8'h20);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
